// File: rtl/axi_arbiter.sv
// Two-master (IFU read, LSU read/write) to one AXI-lite slave arbiter, one transaction at a time.
// Define YSYX_23060251_ARB_RR_EN for round-robin contention between masters; otherwise m1 has fixed priority.
module axi_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // m0 (IFU) read
    input  logic                  m0_arvalid,
    input  logic [ADDR_W-1:0]     m0_araddr,
    output logic                  m0_arready,
    output logic                  m0_rvalid,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic [1:0]            m0_rresp,
    input  logic                  m0_rready,
    // m1 (LSU) read
    input  logic                  m1_arvalid,
    input  logic [ADDR_W-1:0]     m1_araddr,
    output logic                  m1_arready,
    output logic                  m1_rvalid,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic [1:0]            m1_rresp,
    input  logic                  m1_rready,
    // m1 (LSU) write
    input  logic                  m1_awvalid,
    input  logic [ADDR_W-1:0]     m1_awaddr,
    output logic                  m1_awready,
    input  logic                  m1_wvalid,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic                  m1_wready,
    output logic                  m1_bvalid,
    output logic [1:0]            m1_bresp,
    input  logic                  m1_bready,
    // slave read side
    output logic                  s_arvalid,
    output logic [ADDR_W-1:0]     s_araddr,
    input  logic                  s_arready,
    input  logic                  s_rvalid,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic [1:0]            s_rresp,
    output logic                  s_rready,
    // slave write side
    output logic                  s_awvalid,
    output logic [ADDR_W-1:0]     s_awaddr,
    input  logic                  s_awready,
    output logic                  s_wvalid,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_wready,
    input  logic                  s_bvalid,
    input  logic [1:0]            s_bresp,
    output logic                  s_bready,
    // debug: current FSM state (0 IDLE, 1 RD0, 2 RD1, 3 WR1)
    output logic [1:0]            o_dbg_state
);

    // All channels use strict valid/ready: a beat transfers on a rising edge where
    // both are 1; once valid is raised the source holds it and its payload until that edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD0  = 2'd1,
        RD1  = 2'd2,
        WR1  = 2'd3
    } state_t;

    state_t r_state;
    logic   r_ar_done;
    logic   r_aw_done;
    logic   r_w_done;
`ifdef YSYX_23060251_ARB_RR_EN
    logic   r_ptr;  // 1: m1 favoured on the next contention
`endif

    state_t w_grant;
    state_t w_m1_pick;
    logic   w_rd_done;
    logic   w_wr_done;

    assign w_m1_pick = m1_awvalid ? WR1 : RD1;

    always_comb begin
        w_grant = IDLE;
`ifdef YSYX_23060251_ARB_RR_EN
        if ((m1_awvalid || m1_arvalid) && m0_arvalid)
            w_grant = r_ptr ? w_m1_pick : RD0;
        else if (m1_awvalid || m1_arvalid)
            w_grant = w_m1_pick;
        else if (m0_arvalid)
            w_grant = RD0;
`else
        if (m1_awvalid || m1_arvalid)
            w_grant = w_m1_pick;
        else if (m0_arvalid)
            w_grant = RD0;
`endif
    end

    assign w_rd_done = s_rvalid && (((r_state == RD0) && m0_rready) ||
                                    ((r_state == RD1) && m1_rready));
    assign w_wr_done = (r_state == WR1) && s_bvalid && m1_bready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ar_done <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
`ifdef YSYX_23060251_ARB_RR_EN
            r_ptr     <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant != IDLE) begin
                        r_state   <= w_grant;
                        r_ar_done <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
`ifdef YSYX_23060251_ARB_RR_EN
                        r_ptr     <= (w_grant == RD0);
`endif
                    end
                end
                RD0, RD1: begin
                    if (s_arvalid && s_arready)
                        r_ar_done <= 1'b1;
                    if (w_rd_done)
                        r_state <= IDLE;
                end
                WR1: begin
                    if (s_awvalid && s_awready)
                        r_aw_done <= 1'b1;
                    if (s_wvalid && s_wready)
                        r_w_done <= 1'b1;
                    if (w_wr_done)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Response payloads are forwarded untouched; only the handshake bits are steered.
    assign m0_rdata    = s_rdata;
    assign m0_rresp    = s_rresp;
    assign m1_rdata    = s_rdata;
    assign m1_rresp    = s_rresp;
    assign m1_bresp    = s_bresp;
    assign o_dbg_state = r_state;

    always_comb begin
        s_arvalid  = 1'b0;
        s_araddr   = '0;
        s_rready   = 1'b0;
        s_awvalid  = 1'b0;
        s_awaddr   = '0;
        s_wvalid   = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_bready   = 1'b0;
        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bvalid  = 1'b0;
        case (r_state)
            RD0: begin
                s_arvalid  = m0_arvalid && !r_ar_done;
                s_araddr   = m0_araddr;
                m0_arready = s_arready && !r_ar_done;
                m0_rvalid  = s_rvalid;
                s_rready   = m0_rready;
            end
            RD1: begin
                s_arvalid  = m1_arvalid && !r_ar_done;
                s_araddr   = m1_araddr;
                m1_arready = s_arready && !r_ar_done;
                m1_rvalid  = s_rvalid;
                s_rready   = m1_rready;
            end
            WR1: begin
                s_awvalid  = m1_awvalid && !r_aw_done;
                s_awaddr   = m1_awaddr;
                m1_awready = s_awready && !r_aw_done;
                s_wvalid   = m1_wvalid && !r_w_done;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                m1_wready  = s_wready && !r_w_done;
                m1_bvalid  = s_bvalid;
                s_bready   = m1_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_arbiter.sv
// Self-checking bench for axi_arbiter: reset, single read, contention, write, AW/AR priority, mid-transaction reset.
// Expected read data / write responses and grant order are queued when stimulus is set up and popped on output.
module tb_axi_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD0  = 2'd1;
    localparam logic [1:0] S_RD1  = 2'd2;
    localparam logic [1:0] S_WR1  = 2'd3;

    logic clk = 1'b0;
    logic rst;
    logic m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [AW-1:0] m0_araddr;
    logic [DW-1:0] m0_rdata;
    logic [1:0] m0_rresp;
    logic m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [AW-1:0] m1_araddr;
    logic [DW-1:0] m1_rdata;
    logic [1:0] m1_rresp;
    logic m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic [AW-1:0] m1_awaddr;
    logic [DW-1:0] m1_wdata;
    logic [DW/8-1:0] m1_wstrb;
    logic [1:0] m1_bresp;
    logic s_arvalid, s_arready, s_rvalid, s_rready;
    logic [AW-1:0] s_araddr;
    logic [DW-1:0] s_rdata;
    logic [1:0] s_rresp;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [AW-1:0] s_awaddr;
    logic [DW-1:0] s_wdata;
    logic [DW/8-1:0] s_wstrb;
    logic [1:0] s_bresp;
    logic [1:0] dbg_state;

    logic [DW-1:0] exp_q[$];
    logic [1:0]    grant_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    axi_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
        .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awready(m1_awready),
        .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
        .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_arvalid = 0; m0_araddr = '0; m0_rready = 0;
        m1_arvalid = 0; m1_araddr = '0; m1_rready = 0;
        m1_awvalid = 0; m1_awaddr = '0; m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_bready = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 0;
        tick();
        tick();
        rst = 1;
        tick();
    endtask

    // Slave-side read responder: waits for s_arvalid, accepts AR, returns data two cycles later.
    task automatic slave_read(input logic [DW-1:0] data, output logic [1:0] st,
                              output logic [AW-1:0] addr, output logic [DW-1:0] got,
                              output logic rv, output logic other_rdy, output int n);
        n = 0; st = S_IDLE; addr = '0; got = '0; rv = 0; other_rdy = 0;
        while (!s_arvalid && n < 20) begin
            tick();
            n++;
        end
        if (!s_arvalid) return;
        st = dbg_state;
        addr = s_araddr;
        s_arready = 1;
        #1;
        other_rdy = (st == S_RD0) ? (m1_arready | m1_awready) : m0_arready;
        tick();
        s_arready = 0;
        if (st == S_RD0) m0_arvalid = 0;
        else m1_arvalid = 0;
        other_rdy |= (st == S_RD0) ? (m1_arready | m1_awready) : m0_arready;
        tick();
        other_rdy |= (st == S_RD0) ? (m1_arready | m1_awready) : m0_arready;
        tick();
        s_rvalid = 1; s_rdata = data; s_rresp = 2'b00;
        #1;
        got = (st == S_RD0) ? m0_rdata : m1_rdata;
        rv  = (st == S_RD0) ? m0_rvalid : m1_rvalid;
        other_rdy |= (st == S_RD0) ? (m1_arready | m1_awready) : m0_arready;
        tick();
        s_rvalid = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 0;
        m0_arvalid = 1; m1_awvalid = 1; s_rvalid = 1; s_bvalid = 1; s_arready = 1;
        tick();
        tick();
        n_checks++;
        if (dbg_state !== S_IDLE) begin
            n_fail++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, S_IDLE);
        end
        n_checks++;
        if ({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, m0_arready, m1_arready,
             m1_awready, m1_wready, m0_rvalid, m1_rvalid, m1_bvalid} !== 12'h000) begin
            n_fail++; $display("FAIL reset_outputs: got %b exp 0",
                {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready, m0_arready, m1_arready,
                 m1_awready, m1_wready, m0_rvalid, m1_rvalid, m1_bvalid});
        end
        clear_inputs();
        rst = 1;
        tick();
    endtask

    task automatic test_m0_read();
        logic [1:0] st; logic [AW-1:0] addr; logic [DW-1:0] got; logic rv, orr; int n;
        do_reset();
        exp_q.push_back(32'h0000_0413);
        m0_arvalid = 1; m0_araddr = 32'h8000_0000; m0_rready = 1;
        #1;
        n_checks++;
        if (s_arvalid !== 1'b0) begin
            n_fail++; $display("FAIL m0_arvalid_latency0: got %b exp 0", s_arvalid);
        end
        tick();
        n_checks++;
        if (s_arvalid !== 1'b1 || dbg_state !== S_RD0) begin
            n_fail++; $display("FAIL m0_arvalid_latency1: got arvalid=%b st=%0d exp 1/%0d", s_arvalid, dbg_state, S_RD0);
        end
        slave_read(32'h0000_0413, st, addr, got, rv, orr, n);
        n_checks++;
        if (addr !== 32'h8000_0000) begin
            n_fail++; $display("FAIL m0_araddr: got %h exp %h", addr, 32'h8000_0000);
        end
        n_checks++;
        if (rv !== 1'b1 || got !== exp_q.pop_front()) begin
            n_fail++; $display("FAIL m0_rdata: got valid=%b data=%h exp 1/%h", rv, got, 32'h0000_0413);
        end
        n_checks++;
        if (dbg_state !== S_IDLE || m0_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL m0_done_idle: got st=%0d rvalid=%b exp %0d/0", dbg_state, m0_rvalid, S_IDLE);
        end
    endtask

    task automatic test_contention();
        logic [1:0] st, eg; logic [AW-1:0] addr, ea; logic [DW-1:0] got, d; logic rv, orr; int n;
        do_reset();
        for (int i = 0; i < 4; i++) begin
`ifdef YSYX_23060251_ARB_RR_EN
            grant_q.push_back(S_RD0); grant_q.push_back(S_RD1);
`else
            grant_q.push_back(S_RD1); grant_q.push_back(S_RD0);
`endif
            m0_arvalid = 1; m0_araddr = 32'h0000_1000 + i; m0_rready = 1;
            m1_arvalid = 1; m1_araddr = 32'h0000_2000 + i; m1_rready = 1;
            for (int k = 0; k < 2; k++) begin
                d = $urandom;
                exp_q.push_back(d);
                slave_read(d, st, addr, got, rv, orr, n);
                eg = grant_q.pop_front();
                ea = (eg == S_RD0) ? (32'h0000_1000 + i) : (32'h0000_2000 + i);
                n_checks++;
                if (st !== eg || addr !== ea) begin
                    n_fail++; $display("FAIL contention_grant[%0d.%0d]: got st=%0d addr=%h exp %0d/%h", i, k, st, addr, eg, ea);
                end
                n_checks++;
                if (rv !== 1'b1 || got !== exp_q.pop_front() || orr !== 1'b0) begin
                    n_fail++; $display("FAIL contention_data[%0d.%0d]: got valid=%b data=%h other_ready=%b exp 1/%h/0", i, k, rv, got, orr, d);
                end
                if (k == 1) begin
                    n_checks++;
                    if (n < 1) begin
                        n_fail++; $display("FAIL contention_idle_gap[%0d]: got %0d idle cycles exp >=1", i, n);
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_write();
        logic held; int bcnt; logic [1:0] st; logic [AW-1:0] addr; logic [DW-1:0] got, d; logic rv, orr; int n;
        logic [DW-1:0] eb;
        exp_q.push_back(32'h0);
        bcnt = 0;
        m1_awvalid = 1; m1_awaddr = 32'ha000_03f8; m1_wvalid = 1; m1_wdata = 32'h41; m1_wstrb = 4'h1; m1_bready = 1;
        tick();
        m0_arvalid = 1; m0_araddr = 32'h8000_0010; m0_rready = 1;
        #1;
        n_checks++;
        if (dbg_state !== S_WR1 || s_awvalid !== 1'b1 || s_wvalid !== 1'b1) begin
            n_fail++; $display("FAIL wr_grant: got st=%0d aw=%b w=%b exp %0d/1/1", dbg_state, s_awvalid, s_wvalid, S_WR1);
        end
        held = m0_arready | s_arvalid;
        s_wready = 1;
        #1;
        n_checks++;
        if (m1_wready !== 1'b1 || m1_awready !== 1'b0 || s_wdata !== 32'h41 || s_wstrb !== 4'h1) begin
            n_fail++; $display("FAIL wr_w_first: got wready=%b awready=%b wdata=%h wstrb=%h exp 1/0/41/1", m1_wready, m1_awready, s_wdata, s_wstrb);
        end
        tick();
        m1_wvalid = 0; s_wready = 0; s_awready = 1;
        #1;
        held |= m0_arready | s_arvalid; bcnt += int'(m1_bvalid);
        n_checks++;
        if (s_awaddr !== 32'ha000_03f8 || m1_awready !== 1'b1 || s_wvalid !== 1'b0) begin
            n_fail++; $display("FAIL wr_aw_second: got awaddr=%h awready=%b wvalid=%b exp a00003f8/1/0", s_awaddr, m1_awready, s_wvalid);
        end
        tick();
        m1_awvalid = 0; s_awready = 0;
        #1;
        held |= m0_arready | s_arvalid; bcnt += int'(m1_bvalid);
        tick();
        held |= m0_arready | s_arvalid; bcnt += int'(m1_bvalid);
        s_bvalid = 1; s_bresp = 2'b00;
        #1;
        eb = exp_q.pop_front();
        held |= m0_arready | s_arvalid; bcnt += int'(m1_bvalid);
        n_checks++;
        if (m1_bresp !== eb[1:0] || s_bready !== 1'b1) begin
            n_fail++; $display("FAIL wr_bresp: got bresp=%0d bready=%b exp %0d/1", m1_bresp, s_bready, eb[1:0]);
        end
        tick();
        s_bvalid = 0;
        #1;
        bcnt += int'(m1_bvalid); held |= m0_arready | s_arvalid;
        n_checks++;
        if (dbg_state !== S_IDLE) begin
            n_fail++; $display("FAIL wr_done_idle: got %0d exp %0d", dbg_state, S_IDLE);
        end
        n_checks++;
        if (bcnt !== 1 || held !== 1'b0) begin
            n_fail++; $display("FAIL wr_bvalid_pulse: got pulses=%0d m0_served=%b exp 1/0", bcnt, held);
        end
        d = 32'h1234_5678;
        exp_q.push_back(d);
        slave_read(d, st, addr, got, rv, orr, n);
        n_checks++;
        if (st !== S_RD0 || addr !== 32'h8000_0010 || rv !== 1'b1 || got !== exp_q.pop_front()) begin
            n_fail++; $display("FAIL wr_then_m0: got st=%0d addr=%h valid=%b data=%h exp %0d/80000010/1/%h", st, addr, rv, got, S_RD0, d);
        end
        tick();
    endtask

    task automatic test_aw_ar_priority();
        logic [1:0] st; logic [AW-1:0] addr; logic [DW-1:0] got, d, eb; logic rv, orr, saw_ar; int n;
        do_reset();
        exp_q.push_back(32'h2);
        m1_awvalid = 1; m1_awaddr = 32'h0000_0040; m1_wvalid = 1; m1_wdata = 32'hcafe_f00d; m1_wstrb = 4'hf;
        m1_bready = 1; m1_arvalid = 1; m1_araddr = 32'h0000_0080; m1_rready = 1;
        tick();
        n_checks++;
        if (dbg_state !== S_WR1 || s_arvalid !== 1'b0 || s_awvalid !== 1'b1) begin
            n_fail++; $display("FAIL awar_grant: got st=%0d arvalid=%b awvalid=%b exp %0d/0/1", dbg_state, s_arvalid, s_awvalid, S_WR1);
        end
        saw_ar = s_arvalid;
        s_awready = 1; s_wready = 1;
        tick();
        s_awready = 0; s_wready = 0; m1_awvalid = 0; m1_wvalid = 0;
        #1;
        saw_ar |= s_arvalid;
        tick();
        s_bvalid = 1; s_bresp = 2'b10;
        #1;
        eb = exp_q.pop_front();
        saw_ar |= s_arvalid;
        n_checks++;
        if (m1_bvalid !== 1'b1 || m1_bresp !== eb[1:0] || saw_ar !== 1'b0) begin
            n_fail++; $display("FAIL awar_bresp: got bvalid=%b bresp=%0d arvalid_seen=%b exp 1/%0d/0", m1_bvalid, m1_bresp, saw_ar, eb[1:0]);
        end
        tick();
        s_bvalid = 0;
        d = $urandom;
        exp_q.push_back(d);
        slave_read(d, st, addr, got, rv, orr, n);
        n_checks++;
        if (st !== S_RD1 || addr !== 32'h0000_0080 || rv !== 1'b1 || got !== exp_q.pop_front()) begin
            n_fail++; $display("FAIL awar_then_read: got st=%0d addr=%h valid=%b data=%h exp %0d/00000080/1/%h", st, addr, rv, got, S_RD1, d);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m1_arvalid = 1; m1_araddr = 32'h0000_0100; m1_rready = 0;
        tick();
        s_arready = 1;
        tick();
        s_arready = 0; m1_arvalid = 0;
        s_rvalid = 1; s_rdata = 32'h5555_aaaa;
        #1;
        n_checks++;
        if (dbg_state !== S_RD1 || m1_rvalid !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_pending: got st=%0d rvalid=%b exp %0d/1", dbg_state, m1_rvalid, S_RD1);
        end
        rst = 0;
        tick();
        n_checks++;
        if (dbg_state !== S_IDLE || m1_rvalid !== 1'b0 || m0_rvalid !== 1'b0 ||
            {s_arvalid, s_awvalid, s_wvalid} !== 3'b000) begin
            n_fail++; $display("FAIL rstmid_idle: got st=%0d m1_rvalid=%b m0_rvalid=%b s_valids=%b exp %0d/0/0/000",
                dbg_state, m1_rvalid, m0_rvalid, {s_arvalid, s_awvalid, s_wvalid}, S_IDLE);
        end
        rst = 1; s_rvalid = 0;
        tick();
    endtask

    initial begin
        clear_inputs();
        rst = 0;
        test_reset();
        test_m0_read();
        test_contention();
        test_write();
        test_aw_ar_priority();
        test_reset_mid();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: got %0d left exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
